// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multi-cycle multiply / divide unit with HI/LO result registers.
//
// An operation starts on a one-cycle start pulse while idle. The operands and
// opcode are captured, the unit then stays busy for a fixed number of cycles,
// and the whole result is written to hi/lo in one go on the final busy edge.
// While idle, mthi/mtlo copy operand a straight into hi/lo.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears all state
//   start  : one-cycle request to begin the operation selected by md_op
//   md_op  : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   : operands (rs, rt)
//   mthi   : write a to hi (idle only)
//   mtlo   : write a to lo (idle only)
//   busy   : high while an operation is in flight
//   hi, lo : result registers
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic [63:0] prod;
    logic        signed_op;
    logic [31:0] num;
    logic [31:0] den_mag;
    logic [31:0] den;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_ok;

    // Result datapath, evaluated from the captured operands so that a/b may
    // change freely while the unit is running. Division works on magnitudes
    // and fixes signs afterwards; this also makes 0x80000000 / -1 come out as
    // 0x80000000 remainder 0 without any special case. A zero divisor is
    // replaced by 1 only to keep the divider well defined; that result is
    // never written.
    always_comb begin
        signed_op = ~op_q[0];
        if (signed_op)
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        else
            prod = {32'b0, a_q} * {32'b0, b_q};

        num     = (signed_op && a_q[31]) ? -a_q : a_q;
        den_mag = (signed_op && b_q[31]) ? -b_q : b_q;
        div_ok  = (b_q != 32'd0);
        den     = div_ok ? den_mag : 32'd1;
        quo     = num / den;
        rem     = num % den;
        div_lo  = (signed_op && (a_q[31] ^ b_q[31])) ? -quo : quo;
        div_hi  = (signed_op && a_q[31]) ? -rem : rem;
    end

    // Control FSM with registered busy and the hi/lo registers. The counter is
    // loaded with the full latency, so the edge that sees it at 1 is the last
    // busy edge and commits the result. start takes priority over moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= 4'd0;
            op_q  <= 2'b00;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= md_op;
                        count <= md_op[1] ? DIV_LAT : MULT_LAT;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        if (mthi)
                            hi <= a;
                        if (mtlo)
                            lo <= a;
                    end
                end
                RUN: begin
                    if (count == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= 4'd0;
                        if (!op_q[1]) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else if (div_ok) begin
                            hi <= div_hi;
                            lo <= div_lo;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit : self-checking bench for md_unit.
//
// Stimulus pushes the expected hi/lo and busy length of each operation into a
// scoreboard queue; a negedge monitor pops an entry whenever busy falls and
// compares. Expected values come from a plain-arithmetic reference model using
// 64-bit integers. Directed cases cover the documented examples, followed by a
// randomized run with operand/control noise while busy.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monEntry;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hiM = 32'd0;
    logic [31:0] loM = 32'd0;
    int          busyCycles = 0;
    logic        prevBusy = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: architectural result as {hi, lo}.
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] av,
                                              input logic [31:0] bv, input logic [31:0] hOld,
                                              input logic [31:0] lOld);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        case (op)
            2'b00: begin
                sa = $signed(av);
                sb = $signed(bv);
                p  = sa * sb;
                return p;
            end
            2'b01: begin
                p = {32'b0, av} * {32'b0, bv};
                return p;
            end
            default: begin
                if (bv == 32'd0)
                    return {hOld, lOld};
                if (op == 2'b10) begin
                    sa = $signed(av);
                    sb = $signed(bv);
                end else begin
                    sa = {32'b0, av};
                    sb = {32'b0, bv};
                end
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Monitor: a falling busy marks a completed (or aborted) operation.
    always @(negedge clk) begin
        if (busy) begin
            busyCycles++;
        end else if (prevBusy) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedCompletion: got completion expected none");
            end else begin
                monEntry = sbq.pop_front();
                checkOutput("resultHi", hi, monEntry.hi);
                checkOutput("resultLo", lo, monEntry.lo);
                if (monEntry.cycles > 0) begin
                    checks++;
                    if (busyCycles != monEntry.cycles) begin
                        errors++;
                        $display("[TB] FAIL busyLength: got %0d expected %0d", busyCycles, monEntry.cycles);
                    end
                end
            end
            busyCycles = 0;
        end
        prevBusy = busy;
    end

    // Issue one operation (caller is just after a rising edge, unit idle),
    // then wait for completion while checking that hi/lo hold their values.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input bit withMove, input bit noise);
        logic [63:0] r;
        exp_t        e;
        int          n;
        r = refResult(op, av, bv, hiM, loM);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.cycles = op[1] ? DC : MC;
        sbq.push_back(e);
        start = 1'b1;
        md_op = op;
        a = av;
        b = bv;
        mtlo = withMove;
        mthi = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            checkOutput("holdHi", hi, hiM);
            checkOutput("holdLo", lo, loM);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                mthi  = 1'($urandom_range(0, 1));
                mtlo  = 1'($urandom_range(0, 1));
                md_op = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL busyTimeout: got busy=1 expected busy=0");
        end
        hiM = e.hi;
        loM = e.lo;
    endtask

    task automatic applyMove(input bit hEn, input bit lEn, input logic [31:0] val);
        mthi = hEn;
        mtlo = lEn;
        a = val;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (hEn) hiM = val;
        if (lEn) loM = val;
        checkOutput("moveHi", hi, hiM);
        checkOutput("moveLo", lo, loM);
    endtask

    // MULT aborted by reset in its third busy cycle.
    task automatic applyResetAbort();
        exp_t e;
        e.hi = 32'd0;
        e.lo = 32'd0;
        e.cycles = 0;
        sbq.push_back(e);
        start = 1'b1;
        md_op = 2'b00;
        a = 32'h0001_2345;
        b = 32'h0000_0777;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortHi", hi, 32'd0);
        checkOutput("abortLo", lo, 32'd0);
        hiM = 32'd0;
        loM = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("afterAbortBusy", {31'b0, busy}, 32'd0);
        checkOutput("afterAbortHi", hi, 32'd0);
        checkOutput("afterAbortLo", lo, 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          n;

        #1 reset = 1'b1;
        #1;
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        applyMove(1'b1, 1'b0, 32'h1234_5678);
        applyStimulus(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        applyStimulus(2'b01, 32'd5, 32'd7, 1'b1, 1'b0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        applyMove(1'b1, 1'b1, 32'hCAFE_F00D);
        applyResetAbort();

        $display("[TB] randomized cases");
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)
                rb = 32'd0;
            else if (sel == 1)
                rb = 32'($urandom_range(1, 9));
            else if (sel == 2)
                rb = 32'hFFFF_FFFF;
            else
                rb = $urandom;
            if ($urandom_range(0, 3) == 0)
                applyMove(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
